// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/forward control for a 5-stage pipe; 0-cycle combinational outputs.
// Optional operand forwarding under macro HAZ_FORWARD_EN; backpressure is expressed only through pc_we/ifid_we/idex_we.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regwrite,
    input  logic        ex_branch_taken,
    input  logic        ex_mc_start,
    input  logic        mc_done,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic        mc_timeout
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_FLUSH   = 2'b01,
        ST_MC_WAIT = 2'b10,
        ST_BAD     = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  wd_q, wd_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        mc_timeout_q, mc_timeout_d;

    logic        data_hz;
    logic [1:0]  fwd_a_c, fwd_b_c;

    // x0 is hardwired zero, so it never participates in a match
    function automatic logic src_hit(input logic [4:0] src, input logic used,
                                     input logic [4:0] rd, input logic wr);
        return used && wr && (rd != 5'd0) && (src == rd);
    endfunction

`ifdef HAZ_FORWARD_EN
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (src_hit(src, 1'b1, mem_rd, mem_regwrite))
            return 2'b10;
        else if (src_hit(src, 1'b1, wb_rd, wb_regwrite))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    logic unused_inputs;
    assign unused_inputs = ex_regwrite;

    assign data_hz = src_hit(id_rs1, id_use_rs1, ex_rd, ex_memread)
                   | src_hit(id_rs2, id_use_rs2, ex_rd, ex_memread);
    assign fwd_a_c = fwd_sel(ex_rs1);
    assign fwd_b_c = fwd_sel(ex_rs2);
`else
    logic ex_wr;
    logic unused_inputs;
    assign unused_inputs = ^{ex_rs1, ex_rs2, wb_rd, wb_regwrite};

    // Without forwarding, any producer still in EX or MEM must drain first
    assign ex_wr   = ex_regwrite | ex_memread;
    assign data_hz = src_hit(id_rs1, id_use_rs1, ex_rd, ex_wr)
                   | src_hit(id_rs2, id_use_rs2, ex_rd, ex_wr)
                   | src_hit(id_rs1, id_use_rs1, mem_rd, mem_regwrite)
                   | src_hit(id_rs2, id_use_rs2, mem_rd, mem_regwrite);
    assign fwd_a_c = 2'b00;
    assign fwd_b_c = 2'b00;
`endif

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        fwd_a        = fwd_a_c;
        fwd_b        = fwd_b_c;
        state_d      = state_q;
        wd_d         = wd_q;
        mc_timeout_d = mc_timeout_q;

        case (state_q)
            ST_FLUSH: begin
                ifid_flush = 1'b1;
                state_d    = ST_RUN;
            end
            ST_MC_WAIT: begin
                pc_we        = 1'b0;
                ifid_we      = 1'b0;
                idex_we      = 1'b0;
                exmem_bubble = 1'b1;
                wd_d         = wd_q + 6'd1;
                if (mc_done) begin
                    state_d = ST_RUN;
                end else if (wd_q == 6'd63) begin
                    mc_timeout_d = 1'b1;
                    state_d      = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    state_d    = ST_FLUSH;
                end else if (ex_mc_start) begin
                    wd_d    = 6'd0;
                    state_d = ST_MC_WAIT;
                end else if (data_hz) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
        endcase

        if (rst) begin
            pc_we        = 1'b1;
            ifid_we      = 1'b1;
            idex_we      = 1'b1;
            ifid_flush   = 1'b0;
            idex_flush   = 1'b0;
            exmem_bubble = 1'b0;
            fwd_a        = 2'b00;
            fwd_b        = 2'b00;
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_we && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            wd_q         <= 6'd0;
            stall_cnt_q  <= 16'd0;
            mc_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wd_q         <= wd_d;
            stall_cnt_q  <= stall_cnt_d;
            mc_timeout_q <= mc_timeout_d;
        end
    end

    assign state      = state_q;
    assign stall_cnt  = stall_cnt_q;
    assign mc_timeout = mc_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs1, id_use_rs2, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
    logic        ex_branch_taken, ex_mc_start, mc_done;
    logic        pc_we, ifid_we, idex_we, ifid_flush, idex_flush, exmem_bubble;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [15:0] stall_cnt;
    logic        mc_timeout;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_bubble(exmem_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state), .stall_cnt(stall_cnt), .mc_timeout(mc_timeout)
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs1, id_rs2;
        logic       use1, use2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       ex_rw, ex_mr;
        logic [4:0] mem_rd;
        logic       mem_rw;
        logic [4:0] wb_rd;
        logic       wb_rw;
        logic       br, mcs, mcd;
    } in_t;

    typedef struct packed {
        logic        pc_we, ifid_we, idex_we, ifid_flush, idex_flush, exmem_bubble;
        logic [1:0]  fwd_a, fwd_b, state;
        logic [15:0] stall_cnt;
        logic        mc_timeout;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    // Reference model: pipeline mode, MC_WAIT cycles spent so far, stall total, timeout flag
    int   m_mode = 0;
    int   m_waited = 0;
    int   m_stalls = 0;
    bit   m_to = 1'b0;

    function automatic bit hit(logic [4:0] s, bit u, logic [4:0] r, bit w);
        return u && w && (r != 0) && (s == r);
    endfunction

    function automatic logic [1:0] fwd_of(logic [4:0] s, in_t v);
`ifdef HAZ_FORWARD_EN
        if (hit(s, 1'b1, v.mem_rd, v.mem_rw)) return 2'd2;
        if (hit(s, 1'b1, v.wb_rd, v.wb_rw))   return 2'd1;
`endif
        return 2'd0;
    endfunction

    function automatic bit data_hazard(in_t v);
`ifdef HAZ_FORWARD_EN
        return hit(v.id_rs1, v.use1, v.ex_rd, v.ex_mr) || hit(v.id_rs2, v.use2, v.ex_rd, v.ex_mr);
`else
        bit ew = v.ex_rw | v.ex_mr;
        return hit(v.id_rs1, v.use1, v.ex_rd, ew) || hit(v.id_rs2, v.use2, v.ex_rd, ew) ||
               hit(v.id_rs1, v.use1, v.mem_rd, v.mem_rw) || hit(v.id_rs2, v.use2, v.mem_rd, v.mem_rw);
`endif
    endfunction

    task automatic model_cycle(in_t v);
        exp_t e;
        int   nxt;
        e = '0;
        {e.pc_we, e.ifid_we, e.idex_we} = 3'b111;
        e.state      = 2'(m_mode);
        e.stall_cnt  = 16'(m_stalls);
        e.mc_timeout = m_to;
        if (v.rst) begin
            m_mode = 0; m_waited = 0; m_stalls = 0; m_to = 1'b0;
        end else begin
            e.fwd_a = fwd_of(v.ex_rs1, v);
            e.fwd_b = fwd_of(v.ex_rs2, v);
            nxt = 0;
            if (m_mode == 1) begin
                e.ifid_flush = 1'b1;
            end else if (m_mode == 2) begin
                {e.pc_we, e.ifid_we, e.idex_we} = 3'b000;
                e.exmem_bubble = 1'b1;
                m_waited++;
                if (!v.mcd && m_waited < 64) nxt = 2;
                if (!v.mcd && m_waited == 64) m_to = 1'b1;
            end else if (v.br) begin
                e.ifid_flush = 1'b1;
                e.idex_flush = 1'b1;
                nxt = 1;
            end else if (v.mcs) begin
                m_waited = 0;
                nxt = 2;
            end else if (data_hazard(v)) begin
                e.pc_we = 1'b0; e.ifid_we = 1'b0; e.idex_flush = 1'b1;
            end
            if (!e.pc_we && m_stalls < 65535) m_stalls++;
            m_mode = nxt;
        end
        sb_q.push_back(e);
    endtask

    task automatic apply(in_t v);
        rst = v.rst; id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
        ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd; ex_regwrite = v.ex_rw; ex_memread = v.ex_mr;
        mem_rd = v.mem_rd; mem_regwrite = v.mem_rw; wb_rd = v.wb_rd; wb_regwrite = v.wb_rw;
        ex_branch_taken = v.br; ex_mc_start = v.mcs; mc_done = v.mcd;
    endtask

    task automatic step(in_t v);
        @(posedge clk);
        #1;
        apply(v);
        model_cycle(v);
    endtask

    task automatic idle(int n);
        in_t v = '0;
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic chk(string nm, int act, int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("pc_we", int'(pc_we), int'(e.pc_we));
            chk("ifid_we", int'(ifid_we), int'(e.ifid_we));
            chk("idex_we", int'(idex_we), int'(e.idex_we));
            chk("ifid_flush", int'(ifid_flush), int'(e.ifid_flush));
            chk("idex_flush", int'(idex_flush), int'(e.idex_flush));
            chk("exmem_bubble", int'(exmem_bubble), int'(e.exmem_bubble));
            chk("fwd_a", int'(fwd_a), int'(e.fwd_a));
            chk("fwd_b", int'(fwd_b), int'(e.fwd_b));
            chk("state", int'(state), int'(e.state));
            chk("stall_cnt", int'(stall_cnt), int'(e.stall_cnt));
            chk("mc_timeout", int'(mc_timeout), int'(e.mc_timeout));
        end
    end

    initial begin
        in_t v;
        v = '0;
        v.rst = 1'b1;
        apply(v);
        step(v);
        step(v);
        idle(2);

        // load-use on rs1
        v = '0; v.ex_mr = 1'b1; v.ex_rw = 1'b1; v.ex_rd = 5'd5; v.id_rs1 = 5'd5; v.use1 = 1'b1;
        step(v);
        idle(1);
        // x0 never matches
        v = '0; v.ex_mr = 1'b1; v.ex_rw = 1'b1; v.ex_rd = 5'd0; v.id_rs1 = 5'd0; v.use1 = 1'b1;
        step(v);
        // unused source does not stall
        v = '0; v.ex_mr = 1'b1; v.ex_rd = 5'd7; v.id_rs2 = 5'd7; v.use2 = 1'b0;
        step(v);

        // taken branch beats a simultaneous load-use; FLUSH ignores hazards
        v = '0; v.br = 1'b1; v.ex_mr = 1'b1; v.ex_rw = 1'b1; v.ex_rd = 5'd5; v.id_rs1 = 5'd5; v.use1 = 1'b1;
        step(v);
        v.br = 1'b0;
        step(v);
        idle(1);

        // multi-cycle op, mc_done on the fifth wait cycle
        v = '0; v.mcs = 1'b1;
        step(v);
        idle(4);
        v = '0; v.mcd = 1'b1;
        step(v);
        idle(1);
        // mc_done outside MC_WAIT is ignored
        step(v);

        // forwarding / no-forwarding hazard patterns
        v = '0; v.mem_rd = 5'd3; v.mem_rw = 1'b1; v.wb_rd = 5'd3; v.wb_rw = 1'b1; v.ex_rs1 = 5'd3; v.ex_rs2 = 5'd3;
        step(v);
        v.mem_rd = 5'd0;
        step(v);
        v.mem_rd = 5'd3; v.id_rs2 = 5'd3; v.use2 = 1'b1;
        step(v);
        v = '0; v.wb_rd = 5'd4; v.wb_rw = 1'b1; v.id_rs1 = 5'd4; v.use1 = 1'b1;
        step(v);

        // watchdog expiry, then reset in the middle of MC_WAIT
        v = '0; v.mcs = 1'b1;
        step(v);
        idle(70);
        step(v);
        idle(10);
        v = '0; v.rst = 1'b1;
        step(v);
        idle(2);
        // mc_done exactly on the last watchdog cycle avoids a timeout
        v = '0; v.mcs = 1'b1;
        step(v);
        idle(63);
        v = '0; v.mcd = 1'b1;
        step(v);
        idle(2);

        for (int n = 0; n < 4000; n++) begin
            v = '0;
            v.rst    = ($urandom_range(0, 199) == 0);
            v.id_rs1 = 5'($urandom_range(0, 3));
            v.id_rs2 = 5'($urandom_range(0, 3));
            v.use1   = 1'($urandom);
            v.use2   = 1'($urandom);
            v.ex_rs1 = 5'($urandom_range(0, 3));
            v.ex_rs2 = 5'($urandom_range(0, 3));
            v.ex_rd  = 5'($urandom_range(0, 3));
            v.ex_rw  = 1'($urandom);
            v.ex_mr  = ($urandom_range(0, 3) == 0);
            v.mem_rd = 5'($urandom_range(0, 3));
            v.mem_rw = 1'($urandom);
            v.wb_rd  = 5'($urandom_range(0, 3));
            v.wb_rw  = 1'($urandom);
            v.br     = ($urandom_range(0, 11) == 0);
            v.mcs    = ($urandom_range(0, 9) == 0);
            v.mcd    = ($urandom_range(0, 19) == 0);
            step(v);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: id_rs1, id_rs2  in  5 each  source registers of the instruction in ID; id_use_rs1, id_use_rs2  in  1 each  source actually read.
REQ-004 SHALL have: ex_rs1, ex_rs2  in  5 each  sources of the instruction in EX; ex_rd  in  5; ex_regwrite, ex_memread  in  1 each.
REQ-005 SHALL have: mem_rd  in  5; mem_regwrite  in  1; wb_rd  in  5; wb_regwrite  in  1.
REQ-006 SHALL have: ex_branch_taken  in  1  branch/jump resolved taken in EX; ex_mc_start  in  1  multi-cycle op issued in EX; mc_done  in  1  multi-cycle unit finished.
REQ-007 SHALL have: pc_we, ifid_we, idex_we  out  1 each  register enables; ifid_flush, idex_flush, exmem_bubble  out  1 each.
REQ-008 SHALL have: fwd_a, fwd_b  out  2 each  EX operand select (00 regfile, 01 MEM/WB, 10 EX/MEM).
REQ-009 SHALL have: state  out  2  FSM state; stall_cnt  out  16  stall-cycle counter; mc_timeout  out  1  sticky watchdog flag.

Function
REQ-010 SHALL implement FSM RUN=00, FLUSH=01, MC_WAIT=10; 11 unused, SHALL go to RUN next cycle with outputs as RUN.
REQ-011 Register x0 SHALL never match any hazard or forwarding comparison.
REQ-012 Default outputs (no event): pc_we=ifid_we=idex_we=1, all flush/bubble=0.
REQ-013 RUN priority, highest first: ex_branch_taken, ex_mc_start, data hazard.
REQ-014 RUN + ex_branch_taken: same cycle ifid_flush=1, idex_flush=1, pc_we=1; next state FLUSH.
REQ-015 FLUSH: ifid_flush=1 for exactly one cycle, hazards ignored; next state RUN (2-cycle taken-branch penalty).
REQ-016 RUN + ex_mc_start (no branch): next state MC_WAIT; watchdog counter (6-bit) cleared.
REQ-017 MC_WAIT: pc_we=ifid_we=idex_we=0, exmem_bubble=1; watchdog increments each cycle.
REQ-018 MC_WAIT + mc_done: that cycle outputs still stalled; next state RUN. mc_done outside MC_WAIT SHALL be ignored.
REQ-019 MC_WAIT with watchdog reaching 63 and no mc_done: set mc_timeout (sticky until reset); next state RUN.
REQ-020 Load-use hazard in RUN: ex_memread=1, ex_rd!=0, ex_rd equals id_rs1 (id_use_rs1) or id_rs2 (id_use_rs2) -> pc_we=0, ifid_we=0, idex_flush=1 for one cycle; state stays RUN.
REQ-021 Hazard detection and forwarding SHALL be combinational from inputs and state; only state, watchdog, stall_cnt, mc_timeout registered.
REQ-022 stall_cnt SHALL increment every cycle pc_we=0, saturating at 65535.
REQ-023 Register file is write-before-read; WB destinations SHALL never cause a stall.

Reset
REQ-024 rst=1 at a clock edge SHALL force state=RUN, stall_cnt=0, watchdog=0, mc_timeout=0, regardless of state (including mid-MC_WAIT or FLUSH).
REQ-025 While rst=1, outputs SHALL be default values (REQ-012) and fwd_a=fwd_b=00.

Configuration
REQ-026 Macro HAZ_FORWARD_EN defined: fwd_a=10 if mem_regwrite, mem_rd!=0, mem_rd==ex_rs1; else 01 if wb_regwrite, wb_rd!=0, wb_rd==ex_rs1; else 00; fwd_b likewise on ex_rs2. Only load-use stalls (REQ-020).
REQ-027 Macro undefined: fwd_a=fwd_b=00 always; data hazard = any used ID source matching ex_rd (ex_regwrite) or mem_rd (mem_regwrite), nonzero; response as REQ-020, repeated until cleared.

Verification
REQ-028 Load-use: ex_memread=1, ex_rd=5, id_rs1=5 used -> one cycle pc_we=0, ifid_we=0, idex_flush=1, stall_cnt 0->1.
REQ-029 Branch: ex_branch_taken=1 with simultaneous load-use -> cycle T ifid_flush=idex_flush=1, pc_we=1; T+1 state=01, ifid_flush=1; T+2 state=00.
REQ-030 Multi-cycle: ex_mc_start=1, mc_done 4 cycles later -> 5 stall cycles (exmem_bubble=1), then RUN, stall_cnt=5.
REQ-031 Watchdog: ex_mc_start, mc_done never -> mc_timeout=1 after 64 MC_WAIT cycles, state=00; reset mid-MC_WAIT -> state=00, stall_cnt=0, mc_timeout=0.
REQ-032 Forwarding (HAZ_FORWARD_EN): mem_rd=wb_rd=3, both writing, ex_rs1=3 -> fwd_a=10; mem_rd=0 -> fwd_a=01; without macro -> fwd_a=00 and id_rs2=3 used with mem_rd=3 stalls.
